// File: rtl/fft_mdc_ctrl_if.sv
// Control bundle between the MDC FFT sequencer and its surroundings.
// The sequencer is the slave: it receives in_valid and drives all framing outputs.
interface fft_mdc_ctrl_if;
  logic       in_valid;
  logic [6:0] state_code;
  logic [3:0] rom_16_counter;
  logic [2:0] rom_8_counter;
  logic [1:0] rom_4_counter;
  logic       busy;
  logic       out_valid;
  logic       out_last;
  logic       frame_err;

  modport master (
    output in_valid,
    input  state_code,
    input  rom_16_counter,
    input  rom_8_counter,
    input  rom_4_counter,
    input  busy,
    input  out_valid,
    input  out_last,
    input  frame_err
  );

  modport slave (
    input  in_valid,
    output state_code,
    output rom_16_counter,
    output rom_8_counter,
    output rom_4_counter,
    output busy,
    output out_valid,
    output out_last,
    output frame_err
  );
endinterface

// File: rtl/fft_mdc_ctrl.sv
// Sequencing controller for the 32-point radix-2 MDC FFT: commutator state code,
// twiddle ROM addresses and output framing through a LATENCY-deep valid/last line.
module fft_mdc_ctrl #(
  parameter int FRAME_LEN    = 16,
  parameter int LATENCY      = 32,
  parameter int ROM16_OFFSET = 0,
  parameter int ROM8_OFFSET  = 8,
  parameter int ROM4_OFFSET  = 12
) (
  input logic           clk,
  input logic           rst_n,
  fft_mdc_ctrl_if.slave bus
);

  localparam int FPW = $clog2(FRAME_LEN);
  localparam int TW  = (FPW > 4) ? FPW : 4;

  localparam logic [6:0]     LAT_M1    = 7'(LATENCY - 1);
  localparam logic [FPW-1:0] FPOS_LAST = FPW'(FRAME_LEN - 1);
  localparam logic [3:0]     R16       = 4'(ROM16_OFFSET);
  localparam logic [2:0]     R8        = 3'(ROM8_OFFSET);
  localparam logic [1:0]     R4        = 2'(ROM4_OFFSET);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [6:0]     sc_q;
  logic [TW-1:0]  base_q;
  logic [TW-1:0]  base_eff;
  logic [TW-1:0]  t;
  logic [FPW-1:0] fpos;
  logic [6:0]     dc_q;
  logic           restart;
  logic           abort;
  logic           cur_last;
  logic [LATENCY-1:0] line_v;
  logic [LATENCY-1:0] line_l;

  // A restart cycle is frame cycle 0, so the new base is used combinationally
  // in that cycle and registered for the cycles after it.
  always_comb begin
    restart  = (state_q == FLUSH) && bus.in_valid;
    base_eff = restart ? sc_q[TW-1:0] : base_q;
    t        = (state_q == IDLE) ? '0 : (sc_q[TW-1:0] - base_eff);
    fpos     = t[FPW-1:0];
    abort    = (state_q == RUN) && !bus.in_valid && (fpos != '0);
    cur_last = bus.in_valid && (fpos == FPOS_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (!bus.in_valid) state_d = FLUSH;
      end
      FLUSH: begin
        if (bus.in_valid)         state_d = RUN;
        else if (dc_q >= LAT_M1)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sc_q    <= '0;
      base_q  <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        sc_q   <= bus.in_valid ? 7'd1 : '0;
        base_q <= '0;
      end else begin
        sc_q <= sc_q + 7'd1;
        if (restart) base_q <= sc_q[TW-1:0];
      end
      // Cycles since the last accepted sample; saturates so FLUSH can time out.
      if (bus.in_valid)    dc_q <= '0;
      else if (dc_q != '1) dc_q <= dc_q + 7'd1;
    end
  end

  // An abort wipes the partial frame, which after this shift sits in entries 1..fpos.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_v <= '0;
      line_l <= '0;
    end else begin
      line_v[0] <= bus.in_valid;
      line_l[0] <= cur_last;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        if (abort && ((i - 1) < 32'(fpos))) begin
          line_v[i] <= 1'b0;
          line_l[i] <= 1'b0;
        end else begin
          line_v[i] <= line_v[i-1];
          line_l[i] <= line_l[i-1];
        end
      end
    end
  end

  assign bus.state_code     = (state_q == IDLE) ? '0 : sc_q;
  assign bus.rom_16_counter = (state_q == IDLE) ? '0 : (t[3:0] - R16);
  assign bus.rom_8_counter  = (state_q == IDLE) ? '0 : (t[2:0] - R8);
  assign bus.rom_4_counter  = (state_q == IDLE) ? '0 : (t[1:0] - R4);
  assign bus.busy           = (state_q != IDLE);
  assign bus.frame_err      = abort;
  assign bus.out_valid      = line_v[LATENCY-1];
  assign bus.out_last       = line_l[LATENCY-1];

endmodule

// File: tb/tb_fft_mdc_ctrl.sv
// Bench for fft_mdc_ctrl: table of in_valid scenarios with per-cycle expectations,
// a scoreboard for the delayed framing, and a hand sequence for mid-frame reset.
module tb_fft_mdc_ctrl;

  localparam int LAT = 32;
  localparam int FL  = 16;
  localparam int R16 = 0;
  localparam int R8  = 8;
  localparam int R4  = 12;
  localparam int TAIL = 40;

  logic clk = 1'b0;
  logic rst_n;

  fft_mdc_ctrl_if bus ();

  fft_mdc_ctrl #(
    .FRAME_LEN   (FL),
    .LATENCY     (LAT),
    .ROM16_OFFSET(R16),
    .ROM8_OFFSET (R8),
    .ROM4_OFFSET (R4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  // in_valid high for seg1 cycles, low for gap, high for seg2, then low for TAIL.
  typedef struct {
    string name;
    int    seg1;
    int    gap;
    int    seg2;
    int    err_cyc;
    int    idle_cyc;
  } scen_t;

  typedef struct {
    bit v;
    bit l;
  } ent_t;

  scen_t tbl[8];
  ent_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " state_code"}, int'(bus.state_code), 0);
    chk({nm, " rom16"},      int'(bus.rom_16_counter), 0);
    chk({nm, " rom8"},       int'(bus.rom_8_counter), 0);
    chk({nm, " rom4"},       int'(bus.rom_4_counter), 0);
    chk({nm, " busy"},       int'(bus.busy), 0);
    chk({nm, " out_valid"},  int'(bus.out_valid), 0);
    chk({nm, " out_last"},   int'(bus.out_last), 0);
    chk({nm, " frame_err"},  int'(bus.frame_err), 0);
  endtask

  task automatic run_scen(input scen_t s);
    int   s2, total, t, k, n;
    bit   in1, in2, iv, act;
    ent_t e;
    ent_t ne;
    do_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_zero({s.name, " reset"});
    next_cycle();
    sb.delete();
    for (int i = 0; i < LAT; i++) sb.push_back('{v: 1'b0, l: 1'b0});
    s2    = s.seg1 + s.gap;
    total = s2 + s.seg2 + TAIL;
    for (int c = 0; c < total; c++) begin
      in1 = (c < s.seg1);
      in2 = (s.seg2 > 0) && (c >= s2) && (c < s2 + s.seg2);
      iv  = in1 || in2;
      bus.in_valid = iv;
      @(negedge clk);
      act = (c < s.idle_cyc);
      t   = (s.seg2 > 0 && c >= s2) ? (c - s2) : c;
      chk($sformatf("%s c%0d state_code", s.name, c), int'(bus.state_code), act ? (c % 128) : 0);
      chk($sformatf("%s c%0d rom16", s.name, c), int'(bus.rom_16_counter), act ? ((t + 128 - R16) % 16) : 0);
      chk($sformatf("%s c%0d rom8", s.name, c),  int'(bus.rom_8_counter),  act ? ((t + 128 - R8) % 8) : 0);
      chk($sformatf("%s c%0d rom4", s.name, c),  int'(bus.rom_4_counter),  act ? ((t + 128 - R4) % 4) : 0);
      chk($sformatf("%s c%0d busy", s.name, c),  int'(bus.busy), (c >= 1 && c < s.idle_cyc) ? 1 : 0);
      chk($sformatf("%s c%0d frame_err", s.name, c), int'(bus.frame_err), (c == s.err_cyc) ? 1 : 0);
      e = sb.pop_front();
      chk($sformatf("%s c%0d out_valid", s.name, c), int'(bus.out_valid), int'(e.v));
      chk($sformatf("%s c%0d out_last", s.name, c),  int'(bus.out_last),  int'(e.l));
      // Only whole frames of a contiguous segment reach the output.
      ne = '{v: 1'b0, l: 1'b0};
      if (iv) begin
        k = in1 ? c : (c - s2);
        n = in1 ? s.seg1 : s.seg2;
        ne.v = (k < FL * (n / FL));
        ne.l = ne.v && ((k % FL) == FL - 1);
      end
      sb.push_back(ne);
      next_cycle();
    end
  endtask

  initial begin
    tbl[0] = '{name: "single",        seg1: 16,  gap: 0,  seg2: 0,  err_cyc: -1, idle_cyc: 48};
    tbl[1] = '{name: "three_b2b",     seg1: 48,  gap: 0,  seg2: 0,  err_cyc: -1, idle_cyc: 80};
    tbl[2] = '{name: "abort5",        seg1: 5,   gap: 0,  seg2: 0,  err_cyc: 5,  idle_cyc: 37};
    tbl[3] = '{name: "gap3_restart",  seg1: 16,  gap: 3,  seg2: 16, err_cyc: -1, idle_cyc: 67};
    tbl[4] = '{name: "abort_restart", seg1: 21,  gap: 2,  seg2: 16, err_cyc: 21, idle_cyc: 71};
    tbl[5] = '{name: "gap1_restart",  seg1: 16,  gap: 1,  seg2: 16, err_cyc: -1, idle_cyc: 65};
    tbl[6] = '{name: "flush_edge",    seg1: 16,  gap: 31, seg2: 16, err_cyc: -1, idle_cyc: 95};
    tbl[7] = '{name: "wrap9",         seg1: 144, gap: 0,  seg2: 0,  err_cyc: -1, idle_cyc: 176};

    for (int i = 0; i < 8; i++) run_scen(tbl[i]);

    // Reset at frame cycle 9 of the second back-to-back frame.
    do_reset();
    for (int c = 0; c < 25; c++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (c == 24) chk("midrst pre state_code", int'(bus.state_code), 24);
      next_cycle();
    end
    bus.in_valid = 1'b1;
    rst_n        = 1'b0;
    next_cycle();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_zero("midrst after");
    next_cycle();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      chk($sformatf("midrst c%0d out_valid", c), int'(bus.out_valid), 0);
      chk($sformatf("midrst c%0d busy", c),      int'(bus.busy), 0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_mdc_ctrl.md
Name: fft_mdc_ctrl

Overview:
Sequencing controller for the 32-point radix-2 MDC FFT pipeline. It tracks input frames of two samples per cycle (upper/lower lanes, 16 cycles per frame) and drives `state_code` to every stage commutator. It also drives the per-stage twiddle ROM address counters and produces the output-side framing (`out_valid`, `out_last`). It sits beside the five fft_state datapath stages and owns no sample data.

Parameters:
FRAME_LEN, 16, cycles per frame (32 points / 2 lanes); power of two.
LATENCY, 32, cycles from the first input cycle of a frame to its first output cycle; range 1..127.
ROM16_OFFSET, 0, cycle offset of the stage-1 twiddle sequence relative to frame start.
ROM8_OFFSET, 8, cycle offset of the stage-2 twiddle sequence.
ROM4_OFFSET, 12, cycle offset of the stage-3 twiddle sequence.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
in_valid  in  1  a sample pair is present on the datapath inputs this cycle
state_code  out  7  cycle index since the current run started; drives all commutators
rom_16_counter  out  4  stage-1 ROM address
rom_8_counter  out  3  stage-2 ROM address
rom_4_counter  out  2  stage-3 ROM address
busy  out  1  FSM is not IDLE
out_valid  out  1  datapath outputs carry valid FFT data
out_last  out  1  last output cycle of a frame
frame_err  out  1  one-cycle pulse when `in_valid` drops mid-frame

Behaviour:
- Reset (`rst_n`=0 sampled at a `clk` edge):
  - All outputs go to 0, FSM goes to IDLE, all counters and the delay line clear.
  - Reset mid-frame discards all in-flight frames; no `out_valid` appears for them.
- FSM states are IDLE, RUN and FLUSH.
  - IDLE -> RUN when `in_valid`=1. That cycle is frame cycle 0, and `state_code`=0 in that same cycle (combinational from state and `in_valid` in IDLE, registered thereafter).
  - In RUN, `state_code` increments by 1 every cycle, modulo 128. The frame position is `fpos` = `state_code` mod FRAME_LEN.
  - RUN, `fpos`=FRAME_LEN-1 and `in_valid`=1: this is the last cycle of the frame. If `in_valid`=1 on the next cycle, stay in RUN (back-to-back frames, no gap, no bubble). Otherwise go to FLUSH.
  - RUN, `in_valid`=0 with `fpos`≠0: abort. Pulse `frame_err` for one cycle, then go to FLUSH. The partial frame is marked invalid and never raises `out_valid`.
  - FLUSH: `state_code` keeps incrementing because the datapath shift registers run free.
  - FLUSH -> IDLE after the last pending `out_valid`/`out_last` cycle.
  - FLUSH -> RUN if `in_valid`=1 arrives while flushing. That cycle restarts a frame, and `state_code` continues counting without reset. Frame cycle 0 is therefore re-aligned by storing `base` = `state_code` at the restart, and `fpos` = (`state_code` − `base`) mod FRAME_LEN.
- ROM counters, with `t` = `state_code` − `base` (mod 128):
  - `rom_16_counter` = (`t` − ROM16_OFFSET)[3:0]
  - `rom_8_counter` = (`t` − ROM8_OFFSET)[2:0]
  - `rom_4_counter` = (`t` − ROM4_OFFSET)[1:0]
  - All three are 0 in IDLE.
- Output framing:
  - A LATENCY-deep shift line carries a `good` bit (cycle belongs to a complete frame) and a `last` bit.
  - `good` for a whole frame is only known at its final cycle. The line therefore carries a `valid_raw` bit per cycle, and an abort clears the entries of the current partial frame (at most FRAME_LEN−1 entries, indexed from the write pointer).
  - Outputs are registered: `out_valid`(t) = `good`(t−LATENCY) and `out_last`(t) = `last`(t−LATENCY).
  - `busy` = (FSM≠IDLE).
- Wrap-around: `state_code` wraps 127 -> 0 with no effect on framing, because `fpos` is derived mod FRAME_LEN.
- Simultaneous events:
  - Abort and restart cannot coincide, since abort requires `in_valid`=0.
  - The last flush output and a new frame start in the same cycle are both honoured. The FSM goes to RUN and `out_valid` still shows the old frame's final cycle.

Test Plan:
1. Reset, then `in_valid`=1 for 16 cycles:
   - `state_code` reads 0..15 and `rom_8_counter` reads 0..7,0..7 offset by 8 (first value 0 at `t`=8).
   - `out_valid`=1 exactly on cycles 32..47 after the first input, and `out_last` is high on cycle 47.
   - `busy` falls on cycle 48.
2. Three back-to-back frames (48 cycles of `in_valid`=1):
   - `out_valid` is high for 48 continuous cycles.
   - `out_last` pulses at output cycles 15, 31 and 47.
   - `state_code` reaches 47 without reset.
3. Abort: `in_valid`=1 for 5 cycles, then 0:
   - `frame_err` pulses in cycle 5.
   - `out_valid` never asserts.
   - FSM returns to IDLE after LATENCY cycles.
4. Frame, 3-cycle gap, frame (restart during FLUSH):
   - Second frame starts with `fpos`=0 and `rom_16_counter`=0.
   - Both frames emit 16 `out_valid` cycles separated by a 3-cycle gap.
5. Assert `rst_n`=0 at frame cycle 9 of the second of two back-to-back frames: all outputs are 0 next cycle, and no `out_valid` follows for either frame.
6. Run 9 back-to-back frames (144 cycles) to force the `state_code` 127->0 wrap: `out_last` is still spaced every 16 cycles, and the ROM counters stay continuous across the wrap.
